// File: rtl/repairclk_responder.sv
// MBINIT.REPAIRCLK responder: answers init/result/done requests and counts per-lane clock-pattern hits.
// Outputs are registered from the next state and change one cycle after the trigger; busy TX only delays response launch.
module repairclk_responder #(
   parameter int PASS_THRESHOLD = 16,
   parameter int CNT_W          = 5,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       i_MBINIT_CAL_end,
   input  logic [3:0] i_Rx_SbMessage,
   input  logic       i_msg_valid,
   input  logic       i_Busy_SideBand,
   input  logic       i_falling_edge_busy,
   input  logic [2:0] i_lane_pattern_hit,
   output logic [3:0] o_TX_SbMessage,
   output logic       o_ValidOutData,
   output logic [2:0] o_Clock_track_result,
   output logic       o_MBINIT_REPAIRCLK_Detect_En,
   output logic       o_MBINIT_REPAIRCLK_Rx_end,
   output logic       o_train_error_req
);

   localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
   localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
   localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
   localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
   localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
   localparam logic [3:0] MSG_DONE_RESP   = 4'd6;

   localparam logic [3:0] ST_IDLE              = 4'd0;
   localparam logic [3:0] ST_WAIT_INIT_REQ     = 4'd1;
   localparam logic [3:0] ST_CHECK_BUSY_INIT   = 4'd2;
   localparam logic [3:0] ST_SEND_INIT_RESP    = 4'd3;
   localparam logic [3:0] ST_DETECT            = 4'd4;
   localparam logic [3:0] ST_CHECK_BUSY_RESULT = 4'd5;
   localparam logic [3:0] ST_SEND_RESULT_RESP  = 4'd6;
   localparam logic [3:0] ST_WAIT_DONE_REQ     = 4'd7;
   localparam logic [3:0] ST_CHECK_BUSY_DONE   = 4'd8;
   localparam logic [3:0] ST_SEND_DONE_RESP    = 4'd9;
   localparam logic [3:0] ST_DONE              = 4'd10;
   localparam logic [3:0] ST_ERROR             = 4'd11;

   localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [3:0]       state;
   logic [3:0]       next_state;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] hit_cnt [3];
   logic [2:0]       lane_pass;
   logic             init_req_vld;
   logic             result_req_vld;
   logic             done_req_vld;
   logic             timer_active;
   logic             result_accept;

   assign init_req_vld   = i_msg_valid && (i_Rx_SbMessage == MSG_INIT_REQ);
   assign result_req_vld = i_msg_valid && (i_Rx_SbMessage == MSG_RESULT_REQ);
   assign done_req_vld   = i_msg_valid && (i_Rx_SbMessage == MSG_DONE_REQ);
   assign timer_active   = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERROR);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:              next_state = ST_WAIT_INIT_REQ;
         ST_WAIT_INIT_REQ:     if (init_req_vld)
                                  next_state = i_Busy_SideBand ? ST_CHECK_BUSY_INIT : ST_SEND_INIT_RESP;
         ST_CHECK_BUSY_INIT:   if (!i_Busy_SideBand) next_state = ST_SEND_INIT_RESP;
         ST_SEND_INIT_RESP:    if (i_falling_edge_busy) next_state = ST_DETECT;
         ST_DETECT:            if (result_req_vld)
                                  next_state = i_Busy_SideBand ? ST_CHECK_BUSY_RESULT : ST_SEND_RESULT_RESP;
         ST_CHECK_BUSY_RESULT: if (!i_Busy_SideBand) next_state = ST_SEND_RESULT_RESP;
         ST_SEND_RESULT_RESP:  if (i_falling_edge_busy) next_state = ST_WAIT_DONE_REQ;
         ST_WAIT_DONE_REQ:     if (done_req_vld)
                                  next_state = i_Busy_SideBand ? ST_CHECK_BUSY_DONE : ST_SEND_DONE_RESP;
         ST_CHECK_BUSY_DONE:   if (!i_Busy_SideBand) next_state = ST_SEND_DONE_RESP;
         ST_SEND_DONE_RESP:    if (i_falling_edge_busy) next_state = ST_DONE;
         ST_DONE:              next_state = ST_DONE;
         ST_ERROR:             next_state = ST_ERROR;
         default:              next_state = ST_IDLE;
      endcase
      // Enable drop beats timeout, which beats any message-driven move.
      if (timer_active && (timer == TMR_LAST)) next_state = ST_ERROR;
      if (!i_MBINIT_CAL_end) next_state = ST_IDLE;
   end

   assign result_accept = (state == ST_DETECT) &&
                          ((next_state == ST_SEND_RESULT_RESP) || (next_state == ST_CHECK_BUSY_RESULT));

   always_comb begin
      lane_pass = '0;
      for (int i = 0; i < 3; i++)
         lane_pass[i] = ({{(32-CNT_W){1'b0}}, hit_cnt[i]} >= $unsigned(PASS_THRESHOLD));
   end

   always_ff @(posedge CLK) begin
      if (rst || (state == ST_IDLE))
         timer <= '0;
      else if (timer_active)
         timer <= timer + 1'b1;
   end

   // The hit that arrives alongside result_req is deliberately dropped.
   always_ff @(posedge CLK) begin
      if (rst || ((state != ST_DETECT) && (next_state == ST_DETECT))) begin
         for (int i = 0; i < 3; i++) hit_cnt[i] <= '0;
      end else if ((state == ST_DETECT) && !result_req_vld) begin
         for (int i = 0; i < 3; i++)
            if (i_lane_pattern_hit[i] && (hit_cnt[i] != CNT_MAX))
               hit_cnt[i] <= hit_cnt[i] + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state                        <= ST_IDLE;
         o_TX_SbMessage               <= '0;
         o_ValidOutData               <= 1'b0;
         o_Clock_track_result         <= '0;
         o_MBINIT_REPAIRCLK_Detect_En <= 1'b0;
         o_MBINIT_REPAIRCLK_Rx_end    <= 1'b0;
         o_train_error_req            <= 1'b0;
      end else begin
         state                        <= next_state;
         o_MBINIT_REPAIRCLK_Detect_En <= (next_state == ST_DETECT);
         o_MBINIT_REPAIRCLK_Rx_end    <= (next_state == ST_DONE);
         o_train_error_req            <= (next_state == ST_ERROR);
         case (next_state)
            ST_SEND_INIT_RESP: begin
               o_ValidOutData <= 1'b1;
               o_TX_SbMessage <= MSG_INIT_RESP;
            end
            ST_SEND_RESULT_RESP: begin
               o_ValidOutData <= 1'b1;
               o_TX_SbMessage <= MSG_RESULT_RESP;
            end
            ST_SEND_DONE_RESP: begin
               o_ValidOutData <= 1'b1;
               o_TX_SbMessage <= MSG_DONE_RESP;
            end
            default: begin
               o_ValidOutData <= 1'b0;
               o_TX_SbMessage <= '0;
            end
         endcase
         if (next_state == ST_IDLE)
            o_Clock_track_result <= '0;
         else if (result_accept)
            o_Clock_track_result <= lane_pass;
      end
   end

endmodule

// File: tb/tb_repairclk_responder.sv
// Randomized self-checking bench for repairclk_responder against a count-based reference model.
module tb_repairclk_responder;

   localparam int THR = 16;
   localparam int SAT = 31;

   logic       CLK = 1'b0;
   logic       rst;
   logic       cal_end;
   logic       cal_end_to;
   logic [3:0] rx_msg;
   logic       msg_valid;
   logic       busy;
   logic       fall_busy;
   logic [2:0] lane_hit;

   logic [3:0] tx_msg;
   logic       valid_out;
   logic [2:0] track_res;
   logic       detect_en;
   logic       rx_end;
   logic       train_err;

   logic [3:0] t_tx_msg;
   logic       t_valid_out;
   logic [2:0] t_track_res;
   logic       t_detect_en;
   logic       t_rx_end;
   logic       t_train_err;

   int checks = 0;
   int errors = 0;
   int exp_cnt [3];

   always #5 CLK = ~CLK;

   repairclk_responder dut (
      .CLK                          (CLK),
      .rst                          (rst),
      .i_MBINIT_CAL_end             (cal_end),
      .i_Rx_SbMessage               (rx_msg),
      .i_msg_valid                  (msg_valid),
      .i_Busy_SideBand              (busy),
      .i_falling_edge_busy          (fall_busy),
      .i_lane_pattern_hit           (lane_hit),
      .o_TX_SbMessage               (tx_msg),
      .o_ValidOutData               (valid_out),
      .o_Clock_track_result         (track_res),
      .o_MBINIT_REPAIRCLK_Detect_En (detect_en),
      .o_MBINIT_REPAIRCLK_Rx_end    (rx_end),
      .o_train_error_req            (train_err)
   );

   repairclk_responder #(.TIMEOUT_CYCLES(50)) dut_to (
      .CLK                          (CLK),
      .rst                          (rst),
      .i_MBINIT_CAL_end             (cal_end_to),
      .i_Rx_SbMessage               (rx_msg),
      .i_msg_valid                  (msg_valid),
      .i_Busy_SideBand              (busy),
      .i_falling_edge_busy          (fall_busy),
      .i_lane_pattern_hit           (lane_hit),
      .o_TX_SbMessage               (t_tx_msg),
      .o_ValidOutData               (t_valid_out),
      .o_Clock_track_result         (t_track_res),
      .o_MBINIT_REPAIRCLK_Detect_En (t_detect_en),
      .o_MBINIT_REPAIRCLK_Rx_end    (t_rx_end),
      .o_train_error_req            (t_train_err)
   );

   task tick;
      @(posedge CLK);
      #1;
   endtask

   task send_msg(input logic [3:0] code);
      rx_msg = code; msg_valid = 1'b1;
      tick;
      rx_msg = 4'd0; msg_valid = 1'b0;
   endtask

   task pulse_fall;
      fall_busy = 1'b1;
      tick;
      fall_busy = 1'b0;
   endtask

   task test_reset;
      rst = 1'b1; cal_end = 1'b0; cal_end_to = 1'b0; rx_msg = 4'd0; msg_valid = 1'b0;
      busy = 1'b0; fall_busy = 1'b0; lane_hit = 3'b000;
      repeat (2) tick;
      checks++;
      if ({valid_out, tx_msg} !== 5'd0) begin
         errors++; $display("FAIL reset_tx: valid=%b code=%0d, want 0/0", valid_out, tx_msg);
      end
      checks++;
      if ({track_res, detect_en, rx_end, train_err} !== 6'd0) begin
         errors++; $display("FAIL reset_status: res=%b det=%b end=%b err=%b, want all 0",
                            track_res, detect_en, rx_end, train_err);
      end
      rst = 1'b0;
      tick;
      checks++;
      if ({valid_out, detect_en, rx_end, train_err} !== 4'd0) begin
         errors++; $display("FAIL idle_disabled: outputs left 0 expected, got valid=%b det=%b", valid_out, detect_en);
      end
   endtask

   // Full responder handshake; hit counts per lane, busy cycles at init, extra hit alongside result_req.
   task automatic do_flow(input int n0, input int n1, input int n2, input int busy_cyc,
                          input logic [2:0] same_hit, input bit done_in_detect, input string tag);
      int rem [3];
      logic [2:0] h;
      logic [2:0] exp_res;
      rem[0] = n0; rem[1] = n1; rem[2] = n2;
      exp_cnt = '{0, 0, 0};
      cal_end = 1'b1;
      tick;
      checks++;
      if ({valid_out, detect_en, track_res} !== 5'd0) begin
         errors++; $display("FAIL %s wait_init: valid=%b det=%b res=%b, want 0", tag, valid_out, detect_en, track_res);
      end
      busy = (busy_cyc > 0);
      send_msg(4'd1);
      for (int k = 1; k < busy_cyc; k++) begin
         checks++;
         if (valid_out !== 1'b0) begin
            errors++; $display("FAIL %s busy_hold: valid=%b while busy, want 0", tag, valid_out);
         end
         tick;
      end
      if (busy_cyc > 0) begin
         checks++;
         if (valid_out !== 1'b0) begin
            errors++; $display("FAIL %s busy_last: valid=%b, want 0", tag, valid_out);
         end
         busy = 1'b0;
         tick;
      end
      repeat ($urandom_range(0, 2) + 1) begin
         checks++;
         if (valid_out !== 1'b1 || tx_msg !== 4'd2) begin
            errors++; $display("FAIL %s init_resp: valid=%b code=%0d, want 1/2", tag, valid_out, tx_msg);
         end
         tick;
      end
      // the extra tick above landed after the last check; the response must still be held
      pulse_fall;
      checks++;
      if (valid_out !== 1'b0 || detect_en !== 1'b1) begin
         errors++; $display("FAIL %s enter_detect: valid=%b det=%b, want 0/1", tag, valid_out, detect_en);
      end
      while (rem[0] + rem[1] + rem[2] > 0) begin
         h = 3'b000;
         for (int i = 0; i < 3; i++)
            if (rem[i] > 0 && $urandom_range(0, 3) != 0) begin
               h[i] = 1'b1;
               rem[i]--;
               exp_cnt[i] = (exp_cnt[i] < SAT) ? exp_cnt[i] + 1 : SAT;
            end
         lane_hit = h;
         tick;
      end
      lane_hit = 3'b000;
      if (done_in_detect) begin
         send_msg(4'd5);
         checks++;
         if (detect_en !== 1'b1 || valid_out !== 1'b0) begin
            errors++; $display("FAIL %s stray_done: det=%b valid=%b, want 1/0", tag, detect_en, valid_out);
         end
      end
      for (int i = 0; i < 3; i++) exp_res[i] = (exp_cnt[i] >= THR);
      lane_hit = same_hit;
      send_msg(4'd3);
      lane_hit = 3'b000;
      checks++;
      if (valid_out !== 1'b1 || tx_msg !== 4'd4 || track_res !== exp_res || detect_en !== 1'b0) begin
         errors++; $display("FAIL %s result_resp: valid=%b code=%0d res=%b det=%b, want 1/4/%b/0",
                            tag, valid_out, tx_msg, track_res, detect_en, exp_res);
      end
      pulse_fall;
      checks++;
      if (valid_out !== 1'b0 || track_res !== exp_res) begin
         errors++; $display("FAIL %s result_hold: valid=%b res=%b, want 0/%b", tag, valid_out, track_res, exp_res);
      end
      send_msg(4'd6); // a response code on RX is not a request; must be ignored
      send_msg(4'd5);
      checks++;
      if (valid_out !== 1'b1 || tx_msg !== 4'd6) begin
         errors++; $display("FAIL %s done_resp: valid=%b code=%0d, want 1/6", tag, valid_out, tx_msg);
      end
      pulse_fall;
      checks++;
      if (rx_end !== 1'b1 || valid_out !== 1'b0 || train_err !== 1'b0) begin
         errors++; $display("FAIL %s done: end=%b valid=%b err=%b, want 1/0/0", tag, rx_end, valid_out, train_err);
      end
      repeat (3) tick;
      checks++;
      if (rx_end !== 1'b1 || track_res !== exp_res) begin
         errors++; $display("FAIL %s done_level: end=%b res=%b, want 1/%b", tag, rx_end, track_res, exp_res);
      end
      cal_end = 1'b0;
      tick;
      checks++;
      if (rx_end !== 1'b0 || track_res !== 3'b000) begin
         errors++; $display("FAIL %s disable: end=%b res=%b, want 0/000", tag, rx_end, track_res);
      end
   endtask

   task test_normal_flow;
      do_flow(20, 20, 20, 0, 3'b000, 1'b0, "normal");
   endtask

   task test_partial_hits;
      do_flow(16, 15, 40, 0, 3'b000, 1'b0, "partial");
   endtask

   task test_busy_saturation;
      do_flow(20, 3, 100, 5, 3'b000, 1'b0, "busy_sat");
   endtask

   task test_simultaneous;
      do_flow(15, 15, 15, 0, 3'b111, 1'b1, "simul");
   endtask

   task test_random;
      for (int r = 0; r < 4; r++)
         do_flow($urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 35),
                 $urandom_range(0, 3), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
   endtask

   task test_timeout;
      int first;
      first = -1;
      cal_end_to = 1'b1;
      tick;
      send_msg(4'd1);
      pulse_fall;
      checks++;
      if (t_detect_en !== 1'b1) begin
         errors++; $display("FAIL to_detect: det=%b, want 1", t_detect_en);
      end
      for (int k = 3; k <= 60; k++) begin
         tick;
         if (t_train_err === 1'b1 && first < 0) first = k;
      end
      checks++;
      if (first != 50) begin
         errors++; $display("FAIL to_cycle: error at cycle %0d, want 50", first);
      end
      checks++;
      if (t_train_err !== 1'b1 || t_detect_en !== 1'b0) begin
         errors++; $display("FAIL to_level: err=%b det=%b, want 1/0", t_train_err, t_detect_en);
      end
      cal_end_to = 1'b0;
      tick;
      checks++;
      if (t_train_err !== 1'b0) begin
         errors++; $display("FAIL to_clear: err=%b, want 0", t_train_err);
      end
   endtask

   task test_abort;
      cal_end = 1'b1;
      tick;
      send_msg(4'd1);
      pulse_fall;
      lane_hit = 3'b111;
      repeat (20) tick;
      lane_hit = 3'b000;
      send_msg(4'd3);
      checks++;
      if (valid_out !== 1'b1 || tx_msg !== 4'd4 || track_res !== 3'b111) begin
         errors++; $display("FAIL abort_setup: valid=%b code=%0d res=%b, want 1/4/111", valid_out, tx_msg, track_res);
      end
      cal_end = 1'b0;
      tick;
      checks++;
      if ({valid_out, tx_msg, track_res, detect_en, rx_end, train_err} !== 11'd0) begin
         errors++; $display("FAIL abort_drop: valid=%b code=%0d res=%b, want all 0", valid_out, tx_msg, track_res);
      end
      cal_end = 1'b1;
      tick;
      send_msg(4'd1);
      rst = 1'b1;
      tick;
      checks++;
      if ({valid_out, tx_msg, track_res, detect_en, rx_end, train_err} !== 11'd0) begin
         errors++; $display("FAIL abort_rst: valid=%b code=%0d, want all 0", valid_out, tx_msg);
      end
      rst = 1'b0;
      cal_end = 1'b0;
      tick;
      do_flow(10, 10, 10, 0, 3'b000, 1'b0, "restart");
   endtask

   initial begin
      test_reset;
      test_normal_flow;
      test_partial_hits;
      test_busy_saturation;
      test_simultaneous;
      test_random;
      test_timeout;
      test_abort;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/repairclk_responder.md
# repairclk_responder

Responder side of the MBINIT.REPAIRCLK sideband handshake. It answers the partner's init, result and done requests, and enables the local clock-pattern detector. It counts per-lane pattern hits on RCKP, RCKN and RTRK and reports a 3-bit pass/fail result in the result response. It sits in LTSM/MBINIT beside the REPAIRCLK initiator and shares the sideband TX/RX message path with it.

## Interface
- PASS_THRESHOLD, 16: minimum hit count for a lane to pass.
- CNT_W, 5: width of each per-lane saturating hit counter.
- TIMEOUT_CYCLES, 1000: cycles allowed from leaving IDLE to reaching DONE.
- CLK  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_MBINIT_CAL_end  in  1  enable; MBINIT.CAL has finished.
- i_Rx_SbMessage  in  4  decoded RX sideband message code.
- i_msg_valid  in  1  i_Rx_SbMessage is valid this cycle.
- i_Busy_SideBand  in  1  sideband TX is busy.
- i_falling_edge_busy  in  1  one-cycle pulse when TX finishes a message.
- i_lane_pattern_hit  in  3  per-lane one-cycle pulse, one per detected clock-pattern iteration; [0]=RCKP, [1]=RCKN, [2]=RTRK.
- o_TX_SbMessage  out  4  message code to transmit.
- o_ValidOutData  out  1  TX request.
- o_Clock_track_result  out  3  per-lane pass bits, same bit order as i_lane_pattern_hit.
- o_MBINIT_REPAIRCLK_Detect_En  out  1  enables the RX pattern detector.
- o_MBINIT_REPAIRCLK_Rx_end  out  1  responder side complete.
- o_train_error_req  out  1  timeout error.

## Operation
- Message codes:
  - init_req = 1, init_resp = 2
  - result_req = 3, result_resp = 4
  - done_req = 5, done_resp = 6
- States: IDLE, WAIT_INIT_REQ, CHECK_BUSY_INIT, SEND_INIT_RESP, DETECT, CHECK_BUSY_RESULT, SEND_RESULT_RESP, WAIT_DONE_REQ, CHECK_BUSY_DONE, SEND_DONE_RESP, DONE, ERROR.
- Transitions:
  - IDLE -> WAIT_INIT_REQ when i_MBINIT_CAL_end is high.
  - WAIT_INIT_REQ: on valid init_req, go to SEND_INIT_RESP if busy is low, else CHECK_BUSY_INIT.
  - CHECK_BUSY_INIT -> SEND_INIT_RESP when busy is low.
  - SEND_INIT_RESP -> DETECT on i_falling_edge_busy.
  - DETECT: on valid result_req, latch the result, then go to SEND_RESULT_RESP if busy is low, else CHECK_BUSY_RESULT.
  - CHECK_BUSY_RESULT -> SEND_RESULT_RESP when busy is low.
  - SEND_RESULT_RESP -> WAIT_DONE_REQ on i_falling_edge_busy.
  - WAIT_DONE_REQ: on valid done_req, go to SEND_DONE_RESP or CHECK_BUSY_DONE, following the same busy rule.
  - CHECK_BUSY_DONE -> SEND_DONE_RESP when busy is low.
  - SEND_DONE_RESP -> DONE on i_falling_edge_busy.
  - DONE and ERROR hold until i_MBINIT_CAL_end drops.
- i_MBINIT_CAL_end low in any state sends the FSM to IDLE on the next edge. This has priority over every other transition.
- Unexpected or out-of-order message codes are ignored; the FSM holds state.
- Hit counters:
  - Three independent counters, CNT_W bits each, saturating at 2^CNT_W-1.
  - All three clear on the transition into DETECT.
  - They increment only while the current state is DETECT.
  - A hit in the same cycle that result_req is sampled is not counted.
- Result latch: bit i = (count_i >= PASS_THRESHOLD), latched on the cycle result_req is accepted. The latched value is held until the FSM returns to IDLE, and is 0 otherwise.
- Pass/fail is reported only. This block never raises an error for failing lanes; the initiator decides.
- Timeout:
  - The timer clears in IDLE and increments in every other state except DONE and ERROR.
  - When it reaches TIMEOUT_CYCLES-1, the next state is ERROR. Timeout has priority over message transitions.
  - The enable-drop rule still has priority over timeout.
- Outputs are registered and decoded from the next state:
  - SEND_INIT_RESP: o_ValidOutData=1, o_TX_SbMessage=2.
  - SEND_RESULT_RESP: o_ValidOutData=1, o_TX_SbMessage=4.
  - SEND_DONE_RESP: o_ValidOutData=1, o_TX_SbMessage=6.
  - DETECT: Detect_En=1.
  - DONE: Rx_end=1.
  - ERROR: o_train_error_req=1.
  - All other outputs are 0.

## Timing
- Reset value of every output is 0; FSM is in IDLE; counters and timer are 0.
- Outputs change one cycle after the edge at which the triggering input is sampled.
- Example: init_req valid at edge N with busy low gives o_ValidOutData=1 and code 2 from edge N+1.
- o_ValidOutData and the message code stay stable until the edge after i_falling_edge_busy.
- Detect_En rises at the edge after the init_resp falling-busy pulse. It falls at the edge after result_req is accepted.
- Rx_end and o_train_error_req are levels, not pulses. Both clear one cycle after enable drops.
- rst asserted mid-handshake: all outputs are 0 at the next edge.

## Test plan
- Normal flow:
  - Stimulus: enable; init_req; 20 hits per lane; result_req; done_req; a one-cycle falling-busy pulse after each response.
  - Required: responses 2, 4, 6 in order; result 3'b111 with o_ValidOutData for result_resp; Rx_end=1.
- Partial hits:
  - Stimulus: RCKP 16, RCKN 15, RTRK 40 hits.
  - Required: o_Clock_track_result=3'b101; flow still reaches DONE with no error.
- Busy and saturation:
  - Stimulus: busy held high for 5 cycles when init_req arrives; 100 RTRK hits with CNT_W=5.
  - Required: o_ValidOutData stays 0 until busy falls, then asserts; the RTRK counter saturates at 31 without wrapping.
- Simultaneous events and ignored messages:
  - Stimulus: a hit in the same cycle as result_req; a done_req sent while in DETECT.
  - Required: the same-cycle hit is not counted; done_req is ignored and the FSM stays in DETECT.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50, no result_req after init.
  - Required: o_train_error_req=1 about 50 cycles after leaving IDLE; it clears one cycle after enable drops.
- Abort:
  - Stimulus: enable drops during SEND_RESULT_RESP; then rst pulses.
  - Required: all outputs 0 at the next edge; a fresh init_req after re-enable restarts the flow with counters cleared.
